// File: rtl/float_to_fixed_unit.sv
// float16 to signed 8.8 fixed-point converter.
// Multi-cycle serial shifter with a start/done handshake.
module float_to_fixed_unit #(
   parameter int ROUND = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] flt_in,
   output logic [15:0] fix_out,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      SHIFT,
      FINISH
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] flt;
   logic [15:0] mag;
   logic        guard;
   logic        dir;
   logic [4:0]  n;

   logic [4:0]  exp_w;
   logic        is_zero;
   logic        is_sat;
   logic        go_left;
   logic [4:0]  n_dec;
   logic        rnd_bit;
   logic [16:0] rnd_sum;
   logic [15:0] sat_val;

   always_comb begin
      exp_w   = flt[14:10];
      is_zero = (exp_w == 5'd0);
      // exp 22 and above always land outside the 8.8 range
      is_sat  = (exp_w >= 5'd22);
      go_left = (exp_w >= 5'd17);
      n_dec   = go_left ? (exp_w - 5'd17) : (5'd17 - exp_w);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (start) state_nx = DECODE;
         DECODE:
            if (is_zero || is_sat || n_dec == 5'd0)
               state_nx = FINISH;
            else
               state_nx = SHIFT;
         SHIFT:
            if (n == 5'd1) state_nx = FINISH;
         FINISH:
            state_nx = IDLE;
      endcase
   end

   always_comb begin
      rnd_bit = (ROUND != 0) && guard;
      rnd_sum = {1'b0, mag} + {16'd0, rnd_bit};
      sat_val = 16'h0000;
      if (flt[15]) begin
         if (rnd_sum > 17'h08000)
            sat_val = 16'h8000;
         else
            sat_val = ~rnd_sum[15:0] + 16'd1;
      end else begin
         if (rnd_sum > 17'h07FFF)
            sat_val = 16'h7FFF;
         else
            sat_val = rnd_sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         flt     <= 16'h0000;
         mag     <= 16'h0000;
         guard   <= 1'b0;
         dir     <= 1'b0;
         n       <= 5'd0;
         fix_out <= 16'h0000;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  flt  <= flt_in;
                  busy <= 1'b1;
               end
            end
            DECODE: begin
               guard <= 1'b0;
               dir   <= go_left;
               n     <= n_dec;
               // all-ones magnitude forces the saturating path
               if (is_zero)
                  mag <= 16'h0000;
               else if (is_sat)
                  mag <= 16'hFFFF;
               else
                  mag <= {5'd0, 1'b1, flt[9:0]};
            end
            SHIFT: begin
               n <= n - 5'd1;
               if (dir) begin
                  mag <= {mag[14:0], 1'b0};
               end else begin
                  mag   <= {1'b0, mag[15:1]};
                  guard <= mag[0];
               end
            end
            FINISH: begin
               fix_out <= sat_val;
               done    <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_fixed_unit.sv
// Bench for float_to_fixed_unit: directed table, reset abort,
// and back-to-back random operands against a real-valued model.
module tb_float_to_fixed_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] flt_in;
   logic [15:0] fix0, fix1;
   logic        done0, done1;
   logic        busy0, busy1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   float_to_fixed_unit #(.ROUND(0)) u_r0 (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .flt_in  (flt_in),
      .fix_out (fix0),
      .done    (done0),
      .busy    (busy0)
   );

   float_to_fixed_unit #(.ROUND(1)) u_r1 (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .flt_in  (flt_in),
      .fix_out (fix1),
      .done    (done1),
      .busy    (busy1)
   );

   task automatic check(input string tag,
                        input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // value = sig * 2^(exp-17) in 8.8 LSBs; round on the half bit
   function automatic logic [15:0] ref_fix(input logic [15:0] f,
                                           input bit rnd);
      int     e;
      real    v;
      real    fl;
      longint m;
      e = int'(f[14:10]);
      if (e == 0) return 16'h0000;
      if (e == 31) return f[15] ? 16'h8000 : 16'h7FFF;
      v = real'(1024 + int'(f[9:0]));
      for (int i = 0; i < e - 17; i++) v = v * 2.0;
      for (int i = 0; i < 17 - e; i++) v = v / 2.0;
      fl = $floor(v);
      m  = longint'(fl);
      if (rnd && (v - fl) >= 0.5) m = m + 1;
      if (f[15]) m = -m;
      if (m > 32767) m = 32767;
      if (m < -32768) m = -32768;
      return m[15:0];
   endfunction

   function automatic int ref_lat(input logic [15:0] f);
      int e;
      e = int'(f[14:10]);
      if (e == 0 || e >= 22) return 2;
      return 2 + ((e >= 17) ? (e - 17) : (17 - e));
   endfunction

   task automatic do_op(input logic [15:0] f,
                        input bit use_c,
                        input logic [15:0] c0,
                        input logic [15:0] c1);
      int          lat;
      int          cnt;
      logic [15:0] e0, e1;
      e0  = ref_fix(f, 1'b0);
      e1  = ref_fix(f, 1'b1);
      lat = ref_lat(f);
      flt_in = f;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      flt_in = 16'($urandom);
      check("busy_accept", {15'd0, busy0}, 16'd1);
      cnt = 0;
      while (cnt <= 40) begin
         @(posedge clk);
         #1;
         cnt++;
         check("busy_run", {15'd0, busy0}, {15'd0, cnt < lat});
         if (done0) break;
         if (cnt < lat) begin
            start  = 1'($urandom_range(0, 1));
            flt_in = 16'($urandom);
         end
      end
      start = 1'b0;
      check("latency", 16'(cnt), 16'(lat));
      check("done_r1", {15'd0, done1}, 16'd1);
      check("fix_r0", fix0, e0);
      check("fix_r1", fix1, e1);
      if (use_c) begin
         check("const_r0", fix0, c0);
         check("const_r1", fix1, c1);
      end
   endtask

   typedef struct {
      logic [15:0] f;
      logic [15:0] c0;
      logic [15:0] c1;
   } vec_t;

   vec_t vecs[$];
   int   seen_done;

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      flt_in = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_fix", fix0, 16'h0000);
      check("rst_done", {15'd0, done0}, 16'd0);
      check("rst_busy", {15'd0, busy0}, 16'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      vecs.push_back('{16'h3C00, 16'h0100, 16'h0100});
      vecs.push_back('{16'hC000, 16'hFE00, 16'hFE00});
      vecs.push_back('{16'h57FE, 16'h7FE0, 16'h7FE0});
      vecs.push_back('{16'h1C00, 16'h0001, 16'h0001});
      vecs.push_back('{16'h5800, 16'h7FFF, 16'h7FFF});
      vecs.push_back('{16'hD800, 16'h8000, 16'h8000});
      vecs.push_back('{16'hD801, 16'h8000, 16'h8000});
      vecs.push_back('{16'h7C00, 16'h7FFF, 16'h7FFF});
      vecs.push_back('{16'hFC00, 16'h8000, 16'h8000});
      vecs.push_back('{16'h0000, 16'h0000, 16'h0000});
      vecs.push_back('{16'h8000, 16'h0000, 16'h0000});
      vecs.push_back('{16'h0200, 16'h0000, 16'h0000});
      vecs.push_back('{16'h1800, 16'h0000, 16'h0001});
      vecs.push_back('{16'h3C01, 16'h0100, 16'h0100});
      vecs.push_back('{16'h4400, 16'h0400, 16'h0400});
      vecs.push_back('{16'h0400, 16'h0000, 16'h0000});

      foreach (vecs[i]) do_op(vecs[i].f, 1'b1, vecs[i].c0, vecs[i].c1);

      do_op(16'h3C00, 1'b1, 16'h0100, 16'h0100);
      flt_in = 16'h1C00;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_fix0", fix0, 16'h0000);
      check("abort_fix1", fix1, 16'h0000);
      check("abort_busy", {15'd0, busy0}, 16'd0);
      check("abort_done", {15'd0, done0}, 16'd0);
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done0 || done1 || busy0) seen_done++;
      end
      check("abort_quiet", 16'(seen_done), 16'd0);

      for (int i = 0; i < 100; i++)
         do_op(16'($urandom), 1'b0, 16'h0000, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
